mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
//  Consumes the E-stage pipeline register outputs: operands RsE/RtE and the 4-bit MD opcode MADOPE.
//  Signals busy/start to the D-stage hazard logic, which stalls any MD-class instruction in D.
//  Supplies HI/LO to the E-stage result mux for mfhi/mflo.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1, >=MULT_CYCLES)
// PORTS
//  clk      in   1   clock; all state updates on posedge
//  reset    in   1   synchronous, active-high
//  md_op    in   4   MD opcode of instruction in E (MADOPE)
//  rs       in   32  forwarded rs operand in E
//  rt       in   32  forwarded rt operand in E
//  start    out  1   comb: md_op is MULT/MULTU/DIV/DIVU and !busy
//  busy     out  1   registered: operation in flight
//  hi       out  32  current HI register
//  lo       out  32  current LO register
//  rd_data  out  32  comb: HI if md_op==MFHI, LO if md_op==MFLO, else 0
// BEHAVIOUR
//  Opcodes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
//  Opcodes 9-15 are treated as NONE.
//  Reset: busy=0, counter=0, HI=0, LO=0, pending result cleared.
//  Reset mid-operation aborts the operation; the result is never written.
//  Start (edge T, start=1):
//   - Full result is computed combinationally from rs/rt and latched into pend_hi/pend_lo.
//   - counter loads MULT_CYCLES or DIV_CYCLES; busy=1 from T+1.
//  Countdown: counter decrements each cycle while busy.
//  Completion: at the edge where counter==1, HI/LO <= pend_hi/pend_lo and busy <= 0.
//   - busy is high for exactly N cycles; the new HI/LO are visible the cycle busy falls.
//  Arithmetic:
//   - MULT: {HI,LO} = signed 64-bit rs*rt.
//   - MULTU: unsigned 64-bit product.
//   - DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
//   - DIVU: unsigned quotient and remainder.
//   - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
//   - Divisor 0 (DIV or DIVU): the op runs the full DIV_CYCLES with busy, but HI/LO stay unchanged.
//  MTHI/MTLO when !busy: HI (resp. LO) <= rs at the same edge; no busy.
//  Protocol violations (hazard unit prevents these; behaviour still defined):
//   - MD op while busy: start=0, ignored; pending op unaffected.
//   - MTHI/MTLO while busy: ignored.
//   - MFHI/MFLO while busy: rd_data returns the old register value.
//  Back-to-back: a new MD op at the edge where busy falls is legal; it sees the updated HI/LO.
// STRUCTURE
//  Package mdu_pkg: MDOP_* localparam encodings (shared with the controller and the PipeE MADOP field).
//  Package mdu_pkg also holds is_md_class(op) and is_mdstart(op) helper functions.
//  The hazard unit computes stall_md = is_md_class(op_D) && (start || busy).
//  No sub-module: one counter, the HI/LO/pend registers and a combinational mul/div datapath.
//  Counter width: $clog2(DIV_CYCLES+1).
// TESTING
//  1. MULT rs=3, rt=0xFFFFFFFE:
//     -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  2. DIVU 7/2 -> busy high 10 cycles; LO=3, HI=1.
//     DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  3. MTHI rs=0x1234 at !busy, next cycle md_op=MFHI -> rd_data=0x1234, busy stays 0.
//  4. DIV by 0 with HI=0xA, LO=0xB -> busy 10 cycles; HI=0xA, LO=0xB afterwards.
//  5. MULTU 0xFFFFFFFF^2, reset asserted in busy cycle 3:
//     -> busy=0, HI=LO=0 next cycle; no write at the original completion time.
//  6. MULT issued while busy -> start=0; first op completes unchanged.
//     Then a MULT issued on the busy-fall cycle -> start=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared multiply/divide opcode encodings and decode helpers used by the MDU,
// the controller (MADOP field) and the D-stage hazard unit.
package mdu_pkg;

    localparam logic [3:0] MDOP_NONE  = 4'd0;
    localparam logic [3:0] MDOP_MULT  = 4'd1;
    localparam logic [3:0] MDOP_MULTU = 4'd2;
    localparam logic [3:0] MDOP_DIV   = 4'd3;
    localparam logic [3:0] MDOP_DIVU  = 4'd4;
    localparam logic [3:0] MDOP_MFHI  = 4'd5;
    localparam logic [3:0] MDOP_MFLO  = 4'd6;
    localparam logic [3:0] MDOP_MTHI  = 4'd7;
    localparam logic [3:0] MDOP_MTLO  = 4'd8;

    // Any instruction touching HI/LO; the hazard unit stalls these in D
    // while an operation is starting or in flight.
    function automatic logic is_md_class(input logic [3:0] op);
        return (op >= MDOP_MULT) && (op <= MDOP_MTLO);
    endfunction

    // Instructions that launch a multi-cycle multiply or divide.
    function automatic logic is_mdstart(input logic [3:0] op);
        return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// E-stage multi-cycle multiply/divide unit: the full result is computed at
// launch, held in pend_hi/pend_lo, and committed to HI/LO when the count ends.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_pend_hi;
    logic [31:0]   r_pend_lo;
    logic          r_pend_wr;

    logic          w_start;
    logic [63:0]   w_prod_s;
    logic [63:0]   w_prod_u;
    logic          w_signed_div;
    logic          w_rs_neg;
    logic          w_rt_neg;
    logic          w_div_zero;
    logic [31:0]   w_div_a;
    logic [31:0]   w_div_b;
    logic [31:0]   w_div_b_safe;
    logic [31:0]   w_q_mag;
    logic [31:0]   w_r_mag;
    logic [31:0]   w_q;
    logic [31:0]   w_r;
    logic [31:0]   w_res_hi;
    logic [31:0]   w_res_lo;
    logic          w_res_wr;
    logic [CW-1:0] w_load;

    assign w_start = is_mdstart(md_op) && !r_busy;

    // Sign-extending to 64 bits lets one unsigned multiplier produce the
    // two's-complement product modulo 2^64.
    assign w_prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign w_prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide works on magnitudes; 0x80000000 / -1 falls out naturally
    // as quotient 0x80000000, remainder 0.
    assign w_signed_div = (md_op == MDOP_DIV);
    assign w_rs_neg     = w_signed_div && rs[31];
    assign w_rt_neg     = w_signed_div && rt[31];
    assign w_div_a      = w_rs_neg ? (~rs + 32'd1) : rs;
    assign w_div_b      = w_rt_neg ? (~rt + 32'd1) : rt;
    assign w_div_zero   = (rt == 32'd0);
    assign w_div_b_safe = w_div_zero ? 32'd1 : w_div_b;
    assign w_q_mag      = w_div_a / w_div_b_safe;
    assign w_r_mag      = w_div_a % w_div_b_safe;
    assign w_q          = (w_rs_neg ^ w_rt_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r          = w_rs_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_wr = 1'b0;
        w_load   = '0;
        case (md_op)
            MDOP_MULT: begin
                {w_res_hi, w_res_lo} = w_prod_s;
                w_res_wr             = 1'b1;
                w_load               = CW'(MULT_CYCLES);
            end
            MDOP_MULTU: begin
                {w_res_hi, w_res_lo} = w_prod_u;
                w_res_wr             = 1'b1;
                w_load               = CW'(MULT_CYCLES);
            end
            MDOP_DIV, MDOP_DIVU: begin
                w_res_hi = w_r;
                w_res_lo = w_q;
                w_res_wr = !w_div_zero;
                w_load   = CW'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
        end else if (w_start) begin
            r_busy    <= 1'b1;
            r_cnt     <= w_load;
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
        end else if (r_busy) begin
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
                if (r_pend_wr) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end else begin
            // Moves to HI/LO only take effect while idle.
            if (md_op == MDOP_MTHI) r_hi <= rs;
            if (md_op == MDOP_MTLO) r_lo <= rs;
        end
    end

    always_comb begin
        rd_data = '0;
        if (md_op == MDOP_MFHI) rd_data = r_hi;
        else if (md_op == MDOP_MFLO) rd_data = r_lo;
    end

    assign start = w_start;
    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: launches push expected HI/LO and busy
// length; a monitor checks them whenever busy falls.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .md_op   (md_op),
        .rs      (rs),
        .rt      (rt),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Stimulus phase: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_start, input logic [31:0] eh, input logic [31:0] el,
                         input int ncyc, input string name);
        exp_t e;
        md_op = op;
        rs    = a;
        rt    = b;
        #2;
        check({name, " start"}, 64'(start), 64'(exp_start));
        if (exp_start) begin
            e.hi     = eh;
            e.lo     = el;
            e.cycles = ncyc;
            e.name   = name;
            exp_q.push_back(e);
        end
        tick();
        md_op = MDOP_NONE;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (!busy) break;
            tick();
        end
        if (busy) check({name, " idle timeout"}, 64'(busy), 64'd0);
        @(negedge clk);
        tick();
    endtask

    // Monitor: counts busy cycles and compares HI/LO when busy falls.
    initial begin
        int   busy_cnt;
        logic prev_busy;
        exp_t e;
        busy_cnt  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt  = 0;
                prev_busy = 1'b0;
            end else begin
                if (busy) begin
                    busy_cnt++;
                end else if (prev_busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected completion", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, " hi"}, 64'(hi), 64'(e.hi));
                        check({e.name, " lo"}, 64'(lo), 64'(e.lo));
                        check({e.name, " busy cycles"}, 64'(busy_cnt), 64'(e.cycles));
                    end
                    busy_cnt = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        md_op = MDOP_NONE;
        rs    = '0;
        rt    = '0;
        tick();
        tick();
        reset = 1'b0;
        #2;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset start", 64'(start), 64'd0);
        check("reset rd_data", 64'(rd_data), 64'd0);
        tick();

        // Unused opcode behaves as NONE.
        md_op = 4'd9;
        #2;
        check("op9 start", 64'(start), 64'd0);
        check("op9 rd_data", 64'(rd_data), 64'd0);
        tick();

        // 1. Signed multiply: 3 * -2 = -6.
        issue(MDOP_MULT, 32'd3, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult 3*-2");
        wait_idle("mult 3*-2");
        issue(MDOP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 5, "multu max*2");
        wait_idle("multu max*2");

        // 2. Divides.
        issue(MDOP_DIVU, 32'd7, 32'd2, 1'b1, 32'd1, 32'd3, 10, "divu 7/2");
        wait_idle("divu 7/2");
        issue(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div -7/2");
        wait_idle("div -7/2");
        issue(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 10, "div min/-1");
        wait_idle("div min/-1");

        // 3. MTHI then MFHI; MFLO reads LO from the previous divide.
        issue(MDOP_MTHI, 32'h1234, 32'd0, 1'b0, 32'd0, 32'd0, 0, "mthi");
        md_op = MDOP_MFHI;
        #2;
        check("mfhi rd_data", 64'(rd_data), 64'h1234);
        check("mthi busy", 64'(busy), 64'd0);
        tick();
        md_op = MDOP_MFLO;
        #2;
        check("mflo rd_data", 64'(rd_data), 64'h8000_0000);
        tick();

        // 4. Divide by zero leaves HI/LO unchanged.
        issue(MDOP_MTHI, 32'hA, 32'd0, 1'b0, 32'd0, 32'd0, 0, "mthi A");
        issue(MDOP_MTLO, 32'hB, 32'd0, 1'b0, 32'd0, 32'd0, 0, "mtlo B");
        issue(MDOP_DIV, 32'd5, 32'd0, 1'b1, 32'hA, 32'hB, 10, "div by 0");
        wait_idle("div by 0");
        issue(MDOP_DIVU, 32'd9, 32'd0, 1'b1, 32'hA, 32'hB, 10, "divu by 0");
        wait_idle("divu by 0");

        // 5. Reset during busy cycle 3 aborts the operation.
        md_op = MDOP_MULTU;
        rs    = 32'hFFFF_FFFF;
        rt    = 32'hFFFF_FFFF;
        #2;
        check("abort start", 64'(start), 64'd1);
        tick();
        md_op = MDOP_NONE;
        tick();
        tick();
        check("abort busy before reset", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        reset = 1'b0;
        repeat (6) tick();
        check("abort late busy", 64'(busy), 64'd0);
        check("abort late hi", 64'(hi), 64'd0);
        check("abort late lo", 64'(lo), 64'd0);

        // 6. Ops while busy are ignored; back-to-back launch on busy fall.
        issue(MDOP_MULT, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 5, "mult 2*3");
        issue(MDOP_MULT, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 0, "mult while busy");
        issue(MDOP_MTHI, 32'hDEAD, 32'd0, 1'b0, 32'd0, 32'd0, 0, "mthi while busy");
        md_op = MDOP_MFHI;
        #2;
        check("mfhi while busy", 64'(rd_data), 64'd0);
        tick();
        md_op = MDOP_NONE;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick();
        end
        check("b2b busy fell", 64'(busy), 64'd0);
        check("b2b lo visible", 64'(lo), 64'd6);
        issue(MDOP_MULT, 32'd4, 32'd5, 1'b1, 32'd0, 32'd20, 5, "mult b2b");
        wait_idle("mult b2b");

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
